// File: rtl/lsu_req_buffer_if.sv
// Request/control bundle between an LSU request source and the
// lsu_req_buffer. The buffer sits on the slave side.
interface lsu_req_buffer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
);
  localparam int UW = $clog2(DEPTH + 1);

  logic                  flush_i;
  logic [DATA_WIDTH-1:0] req_i;
  logic                  req_valid_i;
  logic                  pop_ld_i;
  logic                  pop_st_i;
  logic [DATA_WIDTH-1:0] ctrl_o;
  logic                  ctrl_valid_o;
  logic                  ready_o;
  logic [UW-1:0]         usage_o;
  logic                  overflow_o;

  modport slave (
    input  flush_i, req_i, req_valid_i, pop_ld_i, pop_st_i,
    output ctrl_o, ctrl_valid_o, ready_o, usage_o, overflow_o
  );

  modport master (
    output flush_i, req_i, req_valid_i, pop_ld_i, pop_st_i,
    input  ctrl_o, ctrl_valid_o, ready_o, usage_o, overflow_o
  );
endinterface

// File: rtl/lsu_req_buffer.sv
// Small circular request buffer in front of the load/store units.
// Up to two entries can leave per cycle (one per consumer). When empty the
// incoming request is bypassed straight to the consumers with no latency.
module lsu_req_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2,
  parameter int READY_MODE = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  lsu_req_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW:0]   DEPTH_W  = (PW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;

  logic          w_empty;
  logic          w_full;
  logic [1:0]    w_npop;
  logic [CW:0]   w_avail;
  logic [1:0]    w_eff_pop;
  logic          w_push_drop;
  logic          w_push_ok;
  logic [CW-1:0] w_count_next;
  logic [PW:0]   w_wsum;
  logic [PW:0]   w_rsum;
  logic [PW-1:0] w_wptr_next;
  logic [PW-1:0] w_rptr_next;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // Pops can only consume what exists this cycle, including a same-cycle
  // push; anything beyond that is ignored.
  assign w_npop    = {1'b0, bus.pop_ld_i} + {1'b0, bus.pop_st_i};
  assign w_avail   = {1'b0, r_count} + (CW + 1)'(bus.req_valid_i);
  assign w_eff_pop = ((CW + 1)'(w_npop) > w_avail) ? w_avail[1:0] : w_npop;

  // A push into a full buffer is only lost when nothing leaves that cycle.
  assign w_push_drop = bus.req_valid_i && w_full && (w_eff_pop == 2'd0);
  assign w_push_ok   = bus.req_valid_i && !w_push_drop;

  assign w_count_next = r_count + CW'(w_push_ok) - CW'(w_eff_pop);

  // Pointers advance by at most DEPTH, so one conditional subtract wraps them.
  assign w_wsum      = {1'b0, r_wptr} + (PW + 1)'(w_push_ok);
  assign w_rsum      = {1'b0, r_rptr} + (PW + 1)'(w_eff_pop);
  assign w_wptr_next = (w_wsum >= DEPTH_W) ? PW'(w_wsum - DEPTH_W) : w_wsum[PW-1:0];
  assign w_rptr_next = (w_rsum >= DEPTH_W) ? PW'(w_rsum - DEPTH_W) : w_rsum[PW-1:0];

  // Occupancy, pointers and sticky overflow; flush wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else if (bus.flush_i) begin
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_wptr  <= w_wptr_next;
      r_rptr  <= w_rptr_next;
      if (w_push_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Entry storage: cleared on reset/flush, written at wptr on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push_ok && (r_wptr == PW'(i))) begin
          r_mem[i] <= bus.req_i;
        end
      end
    end
  end

  assign bus.ctrl_o       = w_empty ? bus.req_i : r_mem[r_rptr];
  assign bus.ctrl_valid_o = w_empty ? bus.req_valid_i : 1'b1;
  assign bus.ready_o      = (READY_MODE != 0) ? !w_full : w_empty;
  assign bus.usage_o      = r_count;
  assign bus.overflow_o   = r_overflow;
endmodule
